// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a core and a DMA requester onto one single-port SRAM (one access at a time, gnt comb in IDLE, done pulse per owner, read data held per requester); ports clk/reset, core_*/dma_* req we addr di gnt done rdata, sram_ADDR/DI/EN/WE/DO, busy; define MEM_ARB_CORE_PRIO_EN for strict core priority instead of round-robin
module mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_di,
  output logic          core_gnt,
  output logic          core_done,
  output logic [DW-1:0] core_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_di,
  output logic          dma_gnt,
  output logic          dma_done,
  output logic [DW-1:0] dma_rdata,
  output logic [AW-1:0] sram_ADDR,
  output logic [DW-1:0] sram_DI,
  output logic          sram_EN,
  output logic          sram_WE,
  input  logic [DW-1:0] sram_DO,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, RDATA, DONE} state_t;
  state_t state;
  logic owner;
  logic we_q;
  logic win_core;
  logic grant;
`ifdef MEM_ARB_CORE_PRIO_EN
  assign win_core = core_req;
`else
  assign win_core = core_req && (!dma_req || owner);
`endif
  assign grant = !reset && state == IDLE && (core_req || dma_req);
  assign core_gnt = grant && win_core;
  assign dma_gnt = grant && !win_core;
  assign core_done = state == DONE && !owner;
  assign dma_done = state == DONE && owner;
  assign sram_EN = state == ISSUE;
  assign sram_WE = state == ISSUE && we_q;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b1;
      we_q       <= 1'b0;
      sram_ADDR  <= '0;
      sram_DI    <= '0;
      core_rdata <= '0;
      dma_rdata  <= '0;
    end else begin
      case (state)
        IDLE: if (grant) begin
          state     <= ISSUE;
          owner     <= !win_core;
          we_q      <= win_core ? core_we : dma_we;
          sram_ADDR <= win_core ? core_addr : dma_addr;
          sram_DI   <= win_core ? core_di : dma_di;
        end
        ISSUE: state <= we_q ? DONE : RDATA;
        RDATA: begin
          state <= DONE;
          if (owner) dma_rdata <= sram_DO;
          else core_rdata <= sram_DO;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven and scoreboard bench for mem_arbiter with a behavioural SRAM
module tb_mem_arbiter;
  logic        clk, reset;
  logic        core_req, core_we, core_gnt, core_done;
  logic [15:0] core_addr;
  logic [31:0] core_di, core_rdata;
  logic        dma_req, dma_we, dma_gnt, dma_done;
  logic [15:0] dma_addr;
  logic [31:0] dma_di, dma_rdata;
  logic [15:0] sram_ADDR;
  logic [31:0] sram_DI, sram_DO;
  logic        sram_EN, sram_WE, busy;
  typedef struct {
    logic        core;
    logic        we;
    logic [15:0] addr;
    logic [31:0] di;
    logic [31:0] rd;
  } vec_t;
  typedef struct {
    logic        core;
    logic        rd_chk;
    logic [31:0] rd;
  } sb_t;
  sb_t         sb[$];
  sb_t         e;
  vec_t        vt[10];
  int          checks = 0, errors = 0;
  logic [31:0] mem [256];
  logic [31:0] exp_crd = 0, exp_drd = 0;

  mem_arbiter #(.AW(16), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_di(core_di),
    .core_gnt(core_gnt), .core_done(core_done), .core_rdata(core_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_di(dma_di),
    .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
    .sram_ADDR(sram_ADDR), .sram_DI(sram_DI), .sram_EN(sram_EN), .sram_WE(sram_WE),
    .sram_DO(sram_DO), .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (sram_EN) begin
      if (sram_WE) mem[sram_ADDR[7:0]] <= sram_DI;
      else sram_DO <= mem[sram_ADDR[7:0]];
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      exp_crd = 0;
      exp_drd = 0;
      chk("rst_core_rdata", core_rdata, 0);
      chk("rst_dma_rdata", dma_rdata, 0);
    end else begin
      if (core_done || dma_done) begin
        chk("one_done", 32'(core_done & dma_done), 0);
        if (sb.size() == 0) chk("spurious_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("done_owner", 32'(core_done), 32'(e.core));
          if (e.rd_chk) begin
            if (e.core) exp_crd = e.rd;
            else exp_drd = e.rd;
          end
        end
      end
      chk("core_rdata", core_rdata, exp_crd);
      chk("dma_rdata", dma_rdata, exp_drd);
    end
  end

  task automatic access(input vec_t v);
    int n;
    if (v.core) begin
      core_req = 1; core_we = v.we; core_addr = v.addr; core_di = v.di;
    end else begin
      dma_req = 1; dma_we = v.we; dma_addr = v.addr; dma_di = v.di;
    end
    #1;
    n = 0;
    while (!(v.core ? core_gnt : dma_gnt) && n < 20) begin
      step();
      n++;
    end
    chk("gnt_seen", 32'(n < 20), 1);
    chk("other_gnt", 32'(v.core ? dma_gnt : core_gnt), 0);
    sb.push_back('{v.core, !v.we, v.rd});
    step();
    core_req = 0;
    dma_req = 0;
    chk("issue_en", 32'(sram_EN), 1);
    chk("issue_we", 32'(sram_WE), 32'(v.we));
    chk("issue_addr", 32'(sram_ADDR), 32'(v.addr));
    if (v.we) chk("issue_di", sram_DI, v.di);
    n = 1;
    while (!(v.core ? core_done : dma_done) && n < 10) begin
      step();
      n++;
    end
    chk("latency", 32'(n), v.we ? 32'd2 : 32'd3);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, 32'h0};
    vt[1] = '{1'b0, 1'b1, 16'h0030, 32'h0BADF00D, 32'h0};
    vt[2] = '{1'b1, 1'b1, 16'h0040, 32'hAAAA5555, 32'h0};
    vt[3] = '{1'b0, 1'b1, 16'h0041, 32'h0000FFFF, 32'h0};
    vt[4] = '{1'b1, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF};
    vt[5] = '{1'b0, 1'b1, 16'h0020, 32'h12345678, 32'h0};
    vt[6] = '{1'b1, 1'b0, 16'h0020, 32'h0, 32'h12345678};
    vt[7] = '{1'b1, 1'b0, 16'h0040, 32'h0, 32'hAAAA5555};
    vt[8] = '{1'b0, 1'b0, 16'h0041, 32'h0, 32'h0000FFFF};
    vt[9] = '{1'b0, 1'b0, 16'h0030, 32'h0, 32'h0BADF00D};
    reset = 1;
    core_req = 1; core_we = 0; core_addr = 0; core_di = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_di = 0;
    step();
    step();
    chk("rst_core_gnt", 32'(core_gnt), 0);
    chk("rst_dma_gnt", 32'(dma_gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_en", 32'(sram_EN), 0);
    chk("rst_we", 32'(sram_WE), 0);
    chk("rst_addr", 32'(sram_ADDR), 0);
    chk("rst_di", sram_DI, 0);
    core_req = 0;
    reset = 0;
    step();
    for (int i = 0; i < 10; i++) access(vt[i]);
    core_req = 1; core_we = 0; core_addr = 16'h0040;
    #1;
    chk("drop_core_gnt", 32'(core_gnt), 1);
    sb.push_back('{1'b1, 1'b1, 32'hAAAA5555});
    step();
    core_req = 0;
    dma_req = 1; dma_we = 1; dma_addr = 16'h0040; dma_di = 32'hFFFFFFFF;
    #1;
    chk("drop_dma_nognt", 32'(dma_gnt), 0);
    step();
    dma_req = 0;
    for (int i = 0; i < 4; i++) begin
      chk("drop_dma_idle", 32'(dma_gnt), 0);
      step();
    end
    chk("drop_busy", 32'(busy), 0);
    access('{1'b1, 1'b0, 16'h0040, 32'h0, 32'hAAAA5555});
    core_req = 1; core_we = 1; core_addr = 16'h0030; core_di = 32'hBAD0BAD0;
    #1;
    chk("abort_gnt", 32'(core_gnt), 1);
    sb.push_back('{1'b1, 1'b0, 32'h0});
    step();
    core_req = 0;
    chk("abort_issue_en", 32'(sram_EN), 1);
    reset = 1;
    #1;
    chk("abort_en", 32'(sram_EN), 0);
    chk("abort_we", 32'(sram_WE), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(core_done), 0);
    step();
    step();
    reset = 0;
    step();
    access('{1'b1, 1'b0, 16'h0030, 32'h0, 32'h0BADF00D});
    reset = 1;
    step();
    step();
    reset = 0;
    step();
    core_req = 1; core_we = 0; core_addr = 16'h0040;
    dma_req = 1; dma_we = 0; dma_addr = 16'h0041;
    #1;
    for (int c = 0; c < 16; c++) begin
`ifdef MEM_ARB_CORE_PRIO_EN
      chk("both_core_gnt", 32'(core_gnt), 32'(c % 4 == 0));
      chk("both_dma_gnt", 32'(dma_gnt), 0);
`else
      chk("both_core_gnt", 32'(core_gnt), 32'(c % 8 == 0));
      chk("both_dma_gnt", 32'(dma_gnt), 32'(c % 8 == 4));
`endif
      if (core_gnt) sb.push_back('{1'b1, 1'b1, 32'hAAAA5555});
      if (dma_gnt) sb.push_back('{1'b0, 1'b1, 32'h0000FFFF});
      step();
    end
    core_req = 0;
    #1;
    chk("lone_dma_gnt", 32'(dma_gnt), 1);
    if (dma_gnt) sb.push_back('{1'b0, 1'b1, 32'h0000FFFF});
    step();
    dma_req = 0;
    repeat (5) step();
    chk("drained", 32'(sb.size()), 0);
    chk("final_busy", 32'(busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 16, SRAM word-address width.
REQ-002 Parameter DW, default 32, SRAM data width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 core_req  input  1  core access request; held with its attributes until core_gnt is sampled high.
REQ-006 core_we  input  1  core write (1) / read (0).
REQ-007 core_addr  input  AW  core word address.
REQ-008 core_di  input  DW  core write data.
REQ-009 core_gnt  output  1  one-cycle pulse; core request accepted this cycle.
REQ-010 core_done  output  1  one-cycle pulse; core access complete.
REQ-011 core_rdata  output  DW  core read data; valid with core_done on reads; held until the next core read completes.
REQ-012 dma_req, dma_we, dma_addr, dma_di, dma_gnt, dma_done, dma_rdata  same directions, widths and meanings as the core_* ports, for the DMA requester.
REQ-013 sram_ADDR  output  AW  SRAM address.
REQ-014 sram_DI  output  DW  SRAM write data.
REQ-015 sram_EN  output  1  SRAM enable.
REQ-016 sram_WE  output  1  SRAM write enable.
REQ-017 sram_DO  input  DW  SRAM read data, valid one cycle after an enabled read.
REQ-018 busy  output  1  high whenever the state is not IDLE.

Function
REQ-019 The FSM states SHALL be IDLE, ISSUE, RDATA and DONE.
REQ-020 IDLE with any req high: the arbiter SHALL drive the winner's gnt high combinationally, latch the winner's we/addr/di and the owner ID, and go to ISSUE; with no req it SHALL stay in IDLE.
REQ-021 ISSUE: sram_EN SHALL be 1, sram_WE SHALL equal the latched we, and sram_ADDR/sram_DI SHALL equal the latched values; next state SHALL be RDATA for a read or DONE for a write.
REQ-022 RDATA: the owner's rdata register SHALL capture sram_DO at the end of the cycle; next state SHALL be DONE.
REQ-023 DONE: the owner's done SHALL be 1 for exactly this cycle; next state SHALL be IDLE.
REQ-024 Latency from gnt SHALL be 3 cycles to done for a read and 2 cycles for a write; no pipelining; at most one access is outstanding.
REQ-025 Outside ISSUE, sram_EN and sram_WE SHALL be 0; sram_ADDR and sram_DI SHALL hold their last values.
REQ-026 Default arbitration SHALL be round-robin: on simultaneous requests, the requester that was not the last owner wins; a lone requester always wins.
REQ-027 The non-owner's gnt, done and rdata SHALL be unaffected by the other requester's access.
REQ-028 A req that drops before gnt SHALL be ignored, with no access issued.

Reset
REQ-029 While reset is high: state SHALL be IDLE; gnt, done, sram_EN, sram_WE and busy SHALL be 0; sram_ADDR, sram_DI and both rdata outputs SHALL be 0; last owner SHALL be DMA, so the core wins the first tie.
REQ-030 Reset mid-access SHALL abort the access: no done pulse, and sram_EN drops immediately.

Configuration
REQ-031 Macro MEM_ARB_CORE_PRIO_EN defined: the core SHALL win every simultaneous request (strict priority), and the DMA SHALL be granted only in IDLE cycles with core_req low.
REQ-032 Macro MEM_ARB_CORE_PRIO_EN undefined: round-robin per REQ-026.

Verification
REQ-033 Core read, addr 0x0010, SRAM word 0xDEADBEEF -> core_gnt at cycle 0, sram_EN=1/WE=0 at cycle 1, core_done with core_rdata=0xDEADBEEF at cycle 3.
REQ-034 DMA write, addr 0x0020, data 0x12345678, then a core read of 0x0020 -> dma_done at cycle 2 after dma_gnt; the core read returns 0x12345678.
REQ-035 Core and DMA both requesting continuously after reset, round-robin -> grants alternate core, dma, core, dma, 4 cycles apart.
REQ-036 Same stimulus as REQ-035 with MEM_ARB_CORE_PRIO_EN defined -> only core_gnt pulses; dma_gnt stays 0 until core_req drops.
REQ-037 Reset asserted during ISSUE of a write to 0x0030 -> sram_EN falls immediately, no done pulse, busy=0, and SRAM 0x0030 is unchanged if reset precedes the clock edge.
REQ-038 Core read of 0x0040 (0xAAAA5555) followed by a DMA read of 0x0041 (0x0000FFFF) -> core_rdata holds 0xAAAA5555 throughout the DMA access.
